// File: rtl/div_ctrl_if.sv
// div_ctrl request/result and divider-core bundle.
// master = control unit + core, slave = div_ctrl.
interface div_ctrl_if;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        core_go;
  logic [31:0] core_dividend;
  logic [31:0] core_divisor;
  logic [31:0] core_quot;
  logic [31:0] core_rem;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, is_signed, op_a, op_b,
    output core_quot, core_rem,
    input  core_go, core_dividend, core_divisor,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, is_signed, op_a, op_b,
    input  core_quot, core_rem,
    output core_go, core_dividend, core_divisor,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/div_ctrl.sv
// DIV/DIVU operand conditioning and sequencing
// around an unsigned divider core; owns HI/LO.
module div_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic       clk,
  input logic       reset_n,
  div_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_FIRE,
    S_WAIT,
    S_FIX,
    S_DONE,
    S_ZERO
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_go;
  logic        w_busy;
  logic        w_done;
  logic        w_dz;

  logic        r_sgn;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [3:0]  r_cnt;
  logic [31:0] r_dvd;
  logic [31:0] r_dvs;
  logic [31:0] r_q;
  logic [31:0] r_r;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // State register; reset abandons any division.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next state and Moore outputs from state.
  always_comb begin
    w_next = r_state;
    w_go   = 1'b0;
    w_busy = 1'b1;
    w_done = 1'b0;
    w_dz   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start)
          w_next = (bus.op_b == 32'd0) ? S_ZERO
                                       : S_SETUP;
      end
      S_SETUP: w_next = S_FIRE;
      S_FIRE: begin
        w_go   = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        w_go = 1'b1;
        if (r_cnt <= 4'd1) w_next = S_FIX;
      end
      S_FIX: w_next = S_DONE;
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      S_ZERO: begin
        w_done = 1'b1;
        w_dz   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, magnitude/sign, result fix-up
  // and HI/LO write, each keyed to the current state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sgn   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a   <= bus.op_a;
            r_b   <= bus.op_b;
            r_sgn <= bus.is_signed;
          end
        end
        S_SETUP: begin
          r_dvd   <= (r_sgn && r_a[31]) ? -r_a : r_a;
          r_dvs   <= (r_sgn && r_b[31]) ? -r_b : r_b;
          r_neg_q <= r_sgn & (r_a[31] ^ r_b[31]);
          r_neg_r <= r_sgn & r_a[31];
        end
        S_FIRE: r_cnt <= 4'(WAIT_CYCLES);
        S_WAIT: r_cnt <= r_cnt - 4'd1;
        S_FIX: begin
          r_q <= r_neg_q ? -bus.core_quot
                         : bus.core_quot;
          r_r <= r_neg_r ? -bus.core_rem
                         : bus.core_rem;
        end
        S_DONE: begin
          r_lo <= r_q;
          r_hi <= r_r;
        end
        default: ;
      endcase
    end
  end

  assign bus.core_go       = w_go;
  assign bus.core_dividend = r_dvd;
  assign bus.core_divisor  = r_dvs;
  assign bus.busy          = w_busy;
  assign bus.done          = w_done;
  assign bus.div_zero      = w_dz;
  assign bus.hi            = r_hi;
  assign bus.lo            = r_lo;

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Operand-conditioning and sequencing stage directly upstream of the unsigned divider core.
- Accepts DIV/DIVU requests from the control unit and captures operands.
- Converts signed operands to magnitudes, pulses the core's start line, waits a fixed settle time and samples the core's quotient/remainder.
- Applies MIPS sign rules and writes the architectural HI (remainder) and LO (quotient) registers.
- Flags divide-by-zero without firing the core.

Parameters:
- WAIT_CYCLES, 1: cycles held in WAIT after the core start pulse before sampling core outputs; legal range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU; captured with start
- op_a  in  32  dividend (rs); captured with start
- op_b  in  32  divisor (rt); captured with start
- core_go  out  1  start strobe to divider core (its divOp); rising edge launches division
- core_dividend  out  32  unsigned magnitude of dividend to core
- core_divisor  out  32  unsigned magnitude of divisor to core
- core_quot  in  32  unsigned quotient from core (core's div_hi)
- core_rem  in  32  unsigned remainder from core (core's div_lo)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when HI/LO updated or div-by-zero reported
- div_zero  out  1  one-cycle pulse, coincident with done, when captured op_b == 0
- hi  out  32  architectural HI register (remainder)
- lo  out  32  architectural LO register (quotient)

Behaviour:
- Reset (async, reset_n=0): state=IDLE; core_go, busy, done, div_zero=0; hi, lo, core_dividend, core_divisor=0; internal sign flags and counter cleared. Reset mid-operation abandons the division; core_go drops immediately; hi/lo read 0.
- Transitions, one per rising edge:
  - IDLE: start=1 -> capture op_a, op_b, is_signed. If op_b==0 -> ZERO, else -> SETUP. start=0 -> stay.
  - SETUP: drive core_dividend/core_divisor with magnitudes. Signed: negate if bit31 set. Unsigned: pass through. Record neg_q = signed & (a31 ^ b31) and neg_r = signed & a31. core_go=0. -> FIRE.
  - FIRE: core_go=1, operands held stable. Load counter with WAIT_CYCLES. -> WAIT.
  - WAIT: core_go stays 1. Counter decrements each cycle; at 1 -> FIX.
  - FIX: core_go=0. Latch q = neg_q ? -core_quot : core_quot and r = neg_r ? -core_rem : core_rem, all 32-bit two's complement, wraparound. -> DONE.
  - DONE: lo<=q, hi<=r, done=1 for this cycle. -> IDLE.
  - ZERO: div_zero=1, done=1 for one cycle; hi/lo unchanged; core_go never asserted. -> IDLE.
- Latency: start sampled at edge E0; done and new hi/lo visible after edge E(4+WAIT_CYCLES). With default WAIT_CYCLES=1, this is E5. Divide-by-zero: done after E1.
- core_go must be low for at least one full cycle (SETUP) before each rise so every request produces a fresh rising edge at the core.
- start while busy: ignored, not queued.
- start on the cycle done is high: state is DONE/ZERO, not IDLE, so start is ignored. It is accepted one cycle later.
- Overflow case, signed 0x80000000 / 0xFFFFFFFF:
  - Magnitudes are 0x80000000 and 1.
  - Quotient 0x80000000, not negated since neg_q=0.
  - Result: lo=0x80000000, hi=0. No flag.
- Signed magnitude of 0x80000000 is 0x80000000, treated as unsigned.
- Outputs hi/lo change only in DONE or on reset.

Test Plan:
- Unsigned: start, is_signed=0, op_a=100, op_b=7 -> core_go rises once, done at E5, lo=14, hi=2, div_zero=0.
- Signed mixed signs: op_a=0xFFFFFF9C (-100), op_b=7, is_signed=1 -> core sees 100/7, lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2). Repeat with op_a=100, op_b=-7 -> lo=-14, hi=2.
- Divide by zero: op_a=55, op_b=0 with hi/lo preset to 3/4 -> done and div_zero high together after E1, core_go never high, hi=3, lo=4.
- Overflow: signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Unsigned 0xFFFFFFFF / 0x10 -> lo=0x0FFFFFFF, hi=0xF.
- Handshake: pulse start again at E2 and on the done cycle -> both ignored, busy stays high until done. Back-to-back request on the cycle after done -> accepted, and core_go shows a low cycle before its second rise.
- Reset mid-op: assert reset_n=0 during WAIT (WAIT_CYCLES=4) -> core_go, busy, hi, lo drop to 0 immediately. After release, a fresh 9/3 request gives lo=3, hi=0 at E8.
